scc_bus_master: RTL and testbench
=================================

Name: scc_bus_master

Overview:
- CPU-side initiator for the Z8530 SCC bus interface.
- Converts a simple req/ack register-access request into correctly timed CE_n/RD_n/WR_n/AB_n/DC_n bus cycles.
- Enforces the SCC's setup, strobe, hold and inter-access recovery times, and synchronises the SCC interrupt line.
- Sits between the CPU bus decoder and the SCC model/pins.

Parameters:
- SETUP_CYC, 1: cycles CE_n and address are low/stable before the strobe; must be >=1.
- STROBE_CYC, 4: cycles RD_n/WR_n are held low; must be >=1.
- HOLD_CYC, 1: cycles CE_n, address and write data are held after the strobe rises; must be >=1.
- RECOVERY_CYC, 6: minimum idle cycles after an access before the next one; must be >=1.
- Parameters are limited to 1..255; an out-of-range value is an elaboration error.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req  in  1  access request; level, held until ack
- we  in  1  1=write, 0=read; sampled with req
- addr  in  2  {AB_n, DC_n} register select; sampled with req
- wdata  in  8  write data; sampled with req
- ack  out  1  one-cycle completion pulse
- rdata  out  8  read data, valid from ack
- busy  out  1  high whenever not IDLE
- irq  out  1  synchronised, active-high SCC interrupt
- scc_ce_n, scc_rd_n, scc_wr_n, scc_ab_n, scc_dc_n  out  1 each  SCC control pins
- scc_d_out  out  8  write data to SCC
- scc_d_oe  out  1  data bus drive enable
- scc_d_in  in  8  read data from SCC
- scc_int_n  in  1  asynchronous SCC INT, active low
- scc_inta_n  out  1  interrupt acknowledge strobe
- iack_req  in  1  interrupt acknowledge request
- iack_ack  out  1  interrupt acknowledge completion pulse
- vector  out  8  acknowledge vector

Behaviour:
- All outputs are registered.
- Reset values: all scc_*_n outputs 1; scc_ab_n/scc_dc_n 1; scc_d_oe 0; scc_d_out 0; ack 0; rdata 0; busy 0; irq 0; iack_ack 0; vector 0.
- FSM states: IDLE, SETUP, STROBE, HOLD, RECOV. One 8-bit down-counter, loaded on each state entry.
- IDLE:
  - req=1 at a clock edge latches we/addr/wdata and enters SETUP.
  - req is ignored in every other state.
- SETUP (SETUP_CYC cycles):
  - ce_n=0; ab_n/dc_n driven from the latched addr.
  - If we=1: d_oe=1 and d_out=wdata.
- STROBE (STROBE_CYC cycles): rd_n=0 (read) or wr_n=0 (write). For reads, rdata captures scc_d_in on the edge leaving STROBE.
- HOLD (HOLD_CYC cycles): strobe high; ce_n, address and write data unchanged.
- RECOV (RECOVERY_CYC cycles):
  - ce_n=1; d_oe=0.
  - ack=1 during the first RECOV cycle only.
  - Then return to IDLE.
- Latency: with defaults, req sampled at edge 0 gives SETUP in cycle 1, STROBE in cycles 2-5, HOLD in cycle 6, ack in cycle 7, RECOV in cycles 7-12, IDLE in cycle 13.
- rdata is held until the next read completes. Writes do not modify rdata.
- Requester handshake: the requester drops req in the cycle after ack. A req still high when IDLE is re-entered starts a new access; this is legal back-to-back operation.
- scc_d_oe is never high while scc_rd_n=0.
- irq = ~scc_int_n after a two-flop synchroniser (2-cycle latency). It is independent of the FSM and keeps running while busy.
- Reset mid-operation: strobes, ce_n and d_oe return to their inactive/0 values asynchronously, and the FSM returns to IDLE. No ack is issued for the aborted access.

Optional Feature:
- SCC_IACK_EN defined:
  - iack_req is accepted in IDLE, with priority over req when both are high in the same cycle.
  - The acknowledge runs the same SETUP/STROBE/HOLD/RECOV sequence with scc_ce_n=1, scc_inta_n=0 from SETUP through HOLD, and scc_rd_n=0 during STROBE.
  - vector captures scc_d_in at the end of STROBE; iack_ack pulses in the first RECOV cycle.
- SCC_IACK_EN undefined:
  - iack_req is ignored; scc_inta_n is constant 1; iack_ack and vector are constant 0.

Decomposition:
- Package scc_pkg holds:
  - the state enum;
  - address constants SCC_B_CTRL=2'b00, SCC_B_DATA=2'b01, SCC_A_CTRL=2'b10, SCC_A_DATA=2'b11;
  - default timing constants.
- One sub-module, sync2: two-flop synchroniser for scc_int_n, with reset value 1 (inactive).

Test Plan:
- Write: req at edge 0 with we=1, addr=2'b01, wdata=8'hA5 -> ce_n low cycles 1-6; wr_n low cycles 2-5; d_oe=1 and d_out=8'hA5 cycles 1-6; ack in cycle 7 only; rd_n stays 1.
- Read: scc_d_in=8'h3C, addr=2'b10, we=0 -> rd_n low cycles 2-5, d_oe=0 throughout, rdata=8'h3C at ack (cycle 7), rdata held after scc_d_in changes.
- Back-to-back: req held high through a second read -> second SETUP no earlier than cycle 14; ce_n high for at least cycles 7-13.
- Reset mid-STROBE: reset_n low in cycle 3 -> wr_n/ce_n high and d_oe=0 immediately; no ack; next req after release completes normally.
- Interrupt: scc_int_n falls while busy -> irq=1 exactly 2 edges later; irq=0 two edges after scc_int_n rises.
- SCC_IACK_EN: iack_req and req high together, scc_d_in=8'h52 -> inta_n low cycles 1-6, ce_n stays 1, vector=8'h52 and iack_ack in cycle 7, then the pending req is served.

Source files
------------

// File: rtl/scc_pkg.sv
// Shared types and constants for the Z8530 SCC bus master.
package scc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD,
    RECOV
  } state_e;

  typedef logic [1:0] scc_addr_t;

  // {AB_n, DC_n} register select encodings
  localparam scc_addr_t SCC_B_CTRL = 2'b00;
  localparam scc_addr_t SCC_B_DATA = 2'b01;
  localparam scc_addr_t SCC_A_CTRL = 2'b10;
  localparam scc_addr_t SCC_A_DATA = 2'b11;

  // Default bus timing, in clock cycles
  localparam int unsigned DEF_SETUP_CYC    = 1;
  localparam int unsigned DEF_STROBE_CYC   = 4;
  localparam int unsigned DEF_HOLD_CYC     = 1;
  localparam int unsigned DEF_RECOVERY_CYC = 6;

  localparam int unsigned CNT_W = 8;

  // Down-counter load value for a phase lasting n cycles
  function automatic logic [CNT_W-1:0] cyc_load(input int unsigned n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/scc_bus_master_if.sv
// CPU request/ack side plus SCC pin side of the bus master.
interface scc_bus_master_if;
  import scc_pkg::*;

  logic       req;
  logic       we;
  scc_addr_t  addr;
  logic [7:0] wdata;
  logic       ack;
  logic [7:0] rdata;
  logic       busy;
  logic       irq;

  logic       scc_ce_n;
  logic       scc_rd_n;
  logic       scc_wr_n;
  logic       scc_ab_n;
  logic       scc_dc_n;
  logic [7:0] scc_d_out;
  logic       scc_d_oe;
  logic [7:0] scc_d_in;
  logic       scc_int_n;
  logic       scc_inta_n;

  logic       iack_req;
  logic       iack_ack;
  logic [7:0] vector;

  modport master (
    input  req, we, addr, wdata, scc_d_in, scc_int_n, iack_req,
    output ack, rdata, busy, irq,
    output scc_ce_n, scc_rd_n, scc_wr_n, scc_ab_n, scc_dc_n,
    output scc_d_out, scc_d_oe, scc_inta_n, iack_ack, vector
  );

  modport slave (
    output req, we, addr, wdata, scc_d_in, scc_int_n, iack_req,
    input  ack, rdata, busy, irq,
    input  scc_ce_n, scc_rd_n, scc_wr_n, scc_ab_n, scc_dc_n,
    input  scc_d_out, scc_d_oe, scc_inta_n, iack_ack, vector
  );
endinterface

// File: rtl/scc_bus_master_sync2.sv
// Two-flop synchroniser; resets to 1 so an active-low input reads inactive.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;

  // Double-register the asynchronous input
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/scc_bus_master.sv
// Z8530 SCC bus master: turns req/ack register accesses into timed
// CE_n/RD_n/WR_n/AB_n/DC_n cycles and synchronises the SCC interrupt.
// Optional interrupt-acknowledge cycles are enabled by defining SCC_IACK_EN.
module scc_bus_master
  import scc_pkg::*;
#(
  parameter int unsigned SETUP_CYC    = DEF_SETUP_CYC,
  parameter int unsigned STROBE_CYC   = DEF_STROBE_CYC,
  parameter int unsigned HOLD_CYC     = DEF_HOLD_CYC,
  parameter int unsigned RECOVERY_CYC = DEF_RECOVERY_CYC
) (
  input  logic             clk,
  input  logic             reset_n,
  scc_bus_master_if.master bus
);

  // Every phase length must fit the 8-bit down-counter and be non-zero
  if (SETUP_CYC == 0 || SETUP_CYC > 255 || STROBE_CYC == 0 || STROBE_CYC > 255 ||
      HOLD_CYC == 0 || HOLD_CYC > 255 || RECOVERY_CYC == 0 || RECOVERY_CYC > 255) begin : g_bad_timing
    $error("scc_bus_master: timing parameters must be in 1..255");
  end

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic             we_q;
  logic             ce_n;
  logic             rd_n;
  logic             wr_n;
  logic             ab_n;
  logic             dc_n;
  logic [7:0]       d_out;
  logic             d_oe;
  logic             ack;
  logic [7:0]       rdata;
  logic             busy;
  logic             int_n_sync;

`ifdef SCC_IACK_EN
  logic             iack_q;
  logic             inta_n;
  logic             iack_ack;
  logic [7:0]       vector;
`endif

  // Bus-cycle sequencer; all pin and handshake outputs are registered here
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= '0;
      we_q   <= 1'b0;
      ce_n   <= 1'b1;
      rd_n   <= 1'b1;
      wr_n   <= 1'b1;
      ab_n   <= 1'b1;
      dc_n   <= 1'b1;
      d_out  <= '0;
      d_oe   <= 1'b0;
      ack    <= 1'b0;
      rdata  <= '0;
      busy   <= 1'b0;
`ifdef SCC_IACK_EN
      iack_q   <= 1'b0;
      inta_n   <= 1'b1;
      iack_ack <= 1'b0;
      vector   <= '0;
`endif
    end else begin
      ack <= 1'b0;
`ifdef SCC_IACK_EN
      iack_ack <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef SCC_IACK_EN
          // Interrupt acknowledge wins over a simultaneous register access
          if (bus.iack_req) begin
            state  <= SETUP;
            cnt    <= cyc_load(SETUP_CYC);
            busy   <= 1'b1;
            iack_q <= 1'b1;
            we_q   <= 1'b0;
            inta_n <= 1'b0;
          end else
`endif
          if (bus.req) begin
            state <= SETUP;
            cnt   <= cyc_load(SETUP_CYC);
            busy  <= 1'b1;
            we_q  <= bus.we;
            ce_n  <= 1'b0;
            ab_n  <= bus.addr[1];
            dc_n  <= bus.addr[0];
`ifdef SCC_IACK_EN
            iack_q <= 1'b0;
`endif
            if (bus.we) begin
              d_oe  <= 1'b1;
              d_out <= bus.wdata;
            end
          end
        end

        SETUP: begin
          if (cnt == '0) begin
            state <= STROBE;
            cnt   <= cyc_load(STROBE_CYC);
            if (we_q) wr_n <= 1'b0;
            else      rd_n <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        STROBE: begin
          if (cnt == '0) begin
            state <= HOLD;
            cnt   <= cyc_load(HOLD_CYC);
            rd_n  <= 1'b1;
            wr_n  <= 1'b1;
`ifdef SCC_IACK_EN
            if (iack_q) vector <= bus.scc_d_in;
            else
`endif
            if (!we_q) rdata <= bus.scc_d_in;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        HOLD: begin
          if (cnt == '0) begin
            state <= RECOV;
            cnt   <= cyc_load(RECOVERY_CYC);
            ce_n  <= 1'b1;
            d_oe  <= 1'b0;
`ifdef SCC_IACK_EN
            inta_n <= 1'b1;
            if (iack_q) iack_ack <= 1'b1;
            else        ack      <= 1'b1;
`else
            ack <= 1'b1;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        RECOV: begin
          if (cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  // Interrupt line synchroniser, free-running regardless of bus activity
  sync2 u_int_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d     (bus.scc_int_n),
    .q     (int_n_sync)
  );

  assign bus.irq       = ~int_n_sync;
  assign bus.ack       = ack;
  assign bus.rdata     = rdata;
  assign bus.busy      = busy;
  assign bus.scc_ce_n  = ce_n;
  assign bus.scc_rd_n  = rd_n;
  assign bus.scc_wr_n  = wr_n;
  assign bus.scc_ab_n  = ab_n;
  assign bus.scc_dc_n  = dc_n;
  assign bus.scc_d_out = d_out;
  assign bus.scc_d_oe  = d_oe;

`ifdef SCC_IACK_EN
  assign bus.scc_inta_n = inta_n;
  assign bus.iack_ack   = iack_ack;
  assign bus.vector     = vector;
`else
  logic unused_iack_req;
  assign unused_iack_req = bus.iack_req;
  assign bus.scc_inta_n  = 1'b1;
  assign bus.iack_ack    = 1'b0;
  assign bus.vector      = '0;
`endif

endmodule

// File: tb/tb_scc_bus_master.sv
// Directed self-checking bench for scc_bus_master (default timing).
module tb_scc_bus_master;
  import scc_pkg::*;

  logic clk;
  logic reset_n;
  int   n_total;
  int   n_bad;
  logic [7:0] exp_rdata;

  scc_bus_master_if bus();

  scc_bus_master dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want done");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Wait (bounded) for an ack pulse, sampling 1ns after each rising edge
  task automatic wait_ack(input string tag, output int cycles);
    bit found;
    found  = 1'b0;
    cycles = 0;
    for (int j = 1; j <= 40; j++) begin
      @(posedge clk);
      #1;
      if (bus.ack) begin
        found  = 1'b1;
        cycles = j;
        break;
      end
    end
    if (!found) check({tag, " ack timeout"}, 32'd0, 32'd1);
  endtask

  // Wait (bounded) for the master to return to idle
  task automatic wait_idle(input string tag);
    bit found;
    found = 1'b0;
    for (int j = 0; j < 40; j++) begin
      @(posedge clk);
      #1;
      if (!bus.busy) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) check({tag, " idle timeout"}, 32'd0, 32'd1);
  endtask

  // One access with cycle-by-cycle pin checks; cycle k sampled 1ns after edge k-1
  task automatic access(input logic w, input logic [1:0] a, input logic [7:0] wd,
                        input logic [7:0] din, input bit keep);
    bit in_ce, in_stb;
    @(negedge clk);
    bus.req      = 1'b1;
    bus.we       = w;
    bus.addr     = a;
    bus.wdata    = wd;
    bus.scc_d_in = din;
    @(posedge clk);
    for (int k = 1; k <= 13; k++) begin
      #1;
      in_ce  = (k >= 1 && k <= 6);
      in_stb = (k >= 2 && k <= 5);
      check($sformatf("ce_n c%0d", k), 32'(bus.scc_ce_n), 32'(!in_ce));
      check($sformatf("rd_n c%0d", k), 32'(bus.scc_rd_n), 32'(!(!w && in_stb)));
      check($sformatf("wr_n c%0d", k), 32'(bus.scc_wr_n), 32'(!(w && in_stb)));
      check($sformatf("d_oe c%0d", k), 32'(bus.scc_d_oe), 32'(w && in_ce));
      check($sformatf("ack c%0d", k), 32'(bus.ack), 32'(k == 7));
      check($sformatf("busy c%0d", k), 32'(bus.busy), 32'(k <= 12));
      check($sformatf("inta_n c%0d", k), 32'(bus.scc_inta_n), 32'd1);
      if (w && in_ce) check($sformatf("d_out c%0d", k), 32'(bus.scc_d_out), 32'(wd));
      if (in_ce) check($sformatf("ab_dc c%0d", k), 32'({bus.scc_ab_n, bus.scc_dc_n}), 32'(a));
      if (k == 1) check("rdata before", 32'(bus.rdata), 32'(exp_rdata));
      if (k == 7) begin
        if (!w) exp_rdata = din;
        bus.scc_d_in = ~din;
      end
      if (k == 7 || k == 12) check($sformatf("rdata c%0d", k), 32'(bus.rdata), 32'(exp_rdata));
      if (k == 8 && !keep) bus.req = 1'b0;
      @(posedge clk);
    end
    if (keep) begin
      #1;
      check("b2b setup c14 ce_n", 32'(bus.scc_ce_n), 32'd0);
      check("b2b setup c14 busy", 32'(bus.busy), 32'd1);
    end
  endtask

  initial begin
    int cyc;
    int ack_cnt;
    n_total   = 0;
    n_bad     = 0;
    exp_rdata = 8'h00;
    reset_n       = 1'b0;
    bus.req       = 1'b0;
    bus.we        = 1'b0;
    bus.addr      = 2'b00;
    bus.wdata     = 8'h00;
    bus.scc_d_in  = 8'h00;
    bus.scc_int_n = 1'b1;
    bus.iack_req  = 1'b0;

    // Reset values
    #12;
    check("rst ce_n", 32'(bus.scc_ce_n), 32'd1);
    check("rst rd_n", 32'(bus.scc_rd_n), 32'd1);
    check("rst wr_n", 32'(bus.scc_wr_n), 32'd1);
    check("rst ab_dc", 32'({bus.scc_ab_n, bus.scc_dc_n}), 32'h3);
    check("rst d_oe", 32'(bus.scc_d_oe), 32'd0);
    check("rst d_out", 32'(bus.scc_d_out), 32'd0);
    check("rst ack", 32'(bus.ack), 32'd0);
    check("rst rdata", 32'(bus.rdata), 32'd0);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst irq", 32'(bus.irq), 32'd0);
    check("rst inta_n", 32'(bus.scc_inta_n), 32'd1);
    check("rst iack_ack", 32'(bus.iack_ack), 32'd0);
    check("rst vector", 32'(bus.vector), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write, then read (rdata must survive the write and a d_in change)
    access(1'b1, SCC_B_DATA, 8'hA5, 8'h00, 1'b0);
    access(1'b0, SCC_A_CTRL, 8'h00, 8'h3C, 1'b0);

    // Back-to-back: req held through a second read
    access(1'b0, SCC_A_DATA, 8'h00, 8'h11, 1'b1);
    bus.scc_d_in = 8'h22;
    wait_ack("b2b", cyc);
    check("b2b ack latency", 32'(cyc), 32'd6);
    exp_rdata = 8'h22;
    check("b2b rdata", 32'(bus.rdata), 32'(exp_rdata));
    bus.req = 1'b0;
    wait_idle("b2b");

    // Reset asserted mid-strobe of a write
    @(negedge clk);
    bus.req   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = SCC_B_CTRL;
    bus.wdata = 8'hC3;
    repeat (3) @(posedge clk);
    #3;
    check("mid wr_n low", 32'(bus.scc_wr_n), 32'd0);
    reset_n = 1'b0;
    #1;
    check("abort wr_n", 32'(bus.scc_wr_n), 32'd1);
    check("abort ce_n", 32'(bus.scc_ce_n), 32'd1);
    check("abort d_oe", 32'(bus.scc_d_oe), 32'd0);
    check("abort busy", 32'(bus.busy), 32'd0);
    bus.req   = 1'b0;
    exp_rdata = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    ack_cnt = 0;
    for (int j = 0; j < 15; j++) begin
      @(posedge clk);
      #1;
      if (bus.ack) ack_cnt++;
    end
    check("abort no ack", 32'(ack_cnt), 32'd0);
    access(1'b1, SCC_B_CTRL, 8'h5A, 8'h00, 1'b0);

    // Interrupt synchroniser while a read is in flight
    @(negedge clk);
    bus.req      = 1'b1;
    bus.we       = 1'b0;
    bus.addr     = SCC_B_DATA;
    bus.scc_d_in = 8'h77;
    @(posedge clk);
    @(posedge clk);
    #1;
    bus.scc_int_n = 1'b0;
    check("irq c2", 32'(bus.irq), 32'd0);
    @(posedge clk); #1;
    check("irq 1 edge", 32'(bus.irq), 32'd0);
    check("irq busy", 32'(bus.busy), 32'd1);
    @(posedge clk); #1;
    check("irq 2 edges", 32'(bus.irq), 32'd1);
    bus.scc_int_n = 1'b1;
    @(posedge clk); #1;
    check("irq rel 1 edge", 32'(bus.irq), 32'd1);
    @(posedge clk); #1;
    check("irq rel 2 edges", 32'(bus.irq), 32'd0);
    wait_ack("irq rd", cyc);
    exp_rdata = 8'h77;
    check("irq rd rdata", 32'(bus.rdata), 32'(exp_rdata));
    bus.req = 1'b0;
    wait_idle("irq rd");

`ifdef SCC_IACK_EN
    // Acknowledge cycle takes priority over a simultaneous write request
    @(negedge clk);
    bus.iack_req = 1'b1;
    bus.req      = 1'b1;
    bus.we       = 1'b1;
    bus.addr     = SCC_A_CTRL;
    bus.wdata    = 8'h9C;
    bus.scc_d_in = 8'h52;
    @(posedge clk);
    for (int k = 1; k <= 13; k++) begin
      #1;
      check($sformatf("iack inta_n c%0d", k), 32'(bus.scc_inta_n), 32'(!(k >= 1 && k <= 6)));
      check($sformatf("iack ce_n c%0d", k), 32'(bus.scc_ce_n), 32'd1);
      check($sformatf("iack rd_n c%0d", k), 32'(bus.scc_rd_n), 32'(!(k >= 2 && k <= 5)));
      check($sformatf("iack wr_n c%0d", k), 32'(bus.scc_wr_n), 32'd1);
      check($sformatf("iack d_oe c%0d", k), 32'(bus.scc_d_oe), 32'd0);
      check($sformatf("iack_ack c%0d", k), 32'(bus.iack_ack), 32'(k == 7));
      check($sformatf("iack ack c%0d", k), 32'(bus.ack), 32'd0);
      if (k == 7) check("iack vector", 32'(bus.vector), 32'h52);
      if (k == 8) bus.iack_req = 1'b0;
      @(posedge clk);
    end
    #1;
    check("iack pending ce_n", 32'(bus.scc_ce_n), 32'd0);
    check("iack pending d_oe", 32'(bus.scc_d_oe), 32'd1);
    wait_ack("iack pending", cyc);
    check("iack pending lat", 32'(cyc), 32'd6);
    bus.req = 1'b0;
    wait_idle("iack pending");
`else
    // Acknowledge requests are ignored in the default build
    @(negedge clk);
    bus.iack_req = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      check("noiack busy", 32'(bus.busy), 32'd0);
      check("noiack inta_n", 32'(bus.scc_inta_n), 32'd1);
      check("noiack iack_ack", 32'(bus.iack_ack), 32'd0);
      check("noiack vector", 32'(bus.vector), 32'd0);
    end
    bus.iack_req = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
